// File: rtl/ign_scheduler_pkg.sv
// Shared definitions for the angle-domain ignition scheduler: FSM state
// encoding, config select codes and default engine-cycle constants.
package ign_scheduler_pkg;

  localparam int ANGLE_MAX_DEF     = 720;
  localparam int MAX_DWELL_CYC_DEF = 20000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } ign_state_e;

  localparam logic CFG_SEL_DWELL = 1'b0;
  localparam logic CFG_SEL_SPARK = 1'b1;

endpackage

// File: rtl/ign_scheduler_channel.sv
// One ignition coil channel: dwell/spark FSM, saturating dwell timer,
// shadow/active angle registers with boundary commit, sticky overdwell flag.
module ign_scheduler_channel
  import ign_scheduler_pkg::*;
#(
  parameter int ANGLE_W       = 10,
  parameter int MAX_DWELL_CYC = MAX_DWELL_CYC_DEF,
  parameter int TMR_W         = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               synced,
  input  logic               tick,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               en,
  input  logic               wr,
  input  logic               wr_sel,
  input  logic [ANGLE_W-1:0] wr_data,
  input  logic               ovd_clr,
  output logic               ign,
  output logic               overdwell
);

  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(MAX_DWELL_CYC - 1);

  ign_state_e         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [ANGLE_W-1:0] dwell_act_q, spark_act_q;
  logic [ANGLE_W-1:0] dwell_sh_q, spark_sh_q;
  logic               pend_q, ovd_q;
  logic               dwell_hit, spark_hit, tmo;
  logic               rel, ovd_set, commit;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Compares always use the currently active angles, even on a commit cycle.
  assign dwell_hit = synced & tick & en & (angle == dwell_act_q) &
                     (dwell_act_q != spark_act_q);
  assign spark_hit = synced & tick & (angle == spark_act_q);
  assign tmo       = (tmr_q == TMR_LIM);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rel     = 1'b0;
    ovd_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dwell_hit) begin
          state_d = ST_DWELL;
          tmr_d   = '0;
        end
      end
      ST_DWELL: begin
        tmr_d   = sat_inc(tmr_q);
        ovd_set = tmo;
        if (spark_hit || !synced || !en || tmo) begin
          state_d = ST_IDLE;
          rel     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow angles only reach the compare at a cycle boundary or right as a
  // dwell ends, so an in-flight spark angle is never replaced.
  assign commit = pend_q & (((state_q == ST_IDLE) & tick & (angle == '0)) | rel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      dwell_act_q <= '0;
      spark_act_q <= '0;
      dwell_sh_q  <= '0;
      spark_sh_q  <= '0;
      pend_q      <= 1'b0;
      ovd_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      if (commit) begin
        dwell_act_q <= dwell_sh_q;
        spark_act_q <= spark_sh_q;
      end
      if (wr) begin
        if (wr_sel == CFG_SEL_SPARK) spark_sh_q <= wr_data;
        else                         dwell_sh_q <= wr_data;
      end
      pend_q <= wr | (pend_q & ~commit);
      ovd_q  <= ovd_set | (ovd_q & ~ovd_clr);
    end
  end

  assign ign       = (state_q == ST_DWELL);
  assign overdwell = ovd_q;

endmodule

// File: rtl/ign_scheduler.sv
// Four-channel ignition scheduler: decodes config writes to the addressed
// channel and concatenates the per-channel coil and overdwell outputs.
module ign_scheduler
  import ign_scheduler_pkg::*;
#(
  parameter int ANGLE_W       = 10,
  parameter int ANGLE_MAX     = ANGLE_MAX_DEF,
  parameter int MAX_DWELL_CYC = MAX_DWELL_CYC_DEF,
  parameter int TMR_W         = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               synced,
  input  logic               tick,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_ch,
  input  logic               cfg_sel,
  input  logic [ANGLE_W-1:0] cfg_data,
  input  logic [3:0]         ch_en,
  input  logic               ovd_clr,
  output logic [3:0]         ign,
  output logic [3:0]         overdwell
);

  localparam logic [ANGLE_W-1:0] ANGLE_LIM = ANGLE_W'(ANGLE_MAX);

  // Out-of-range angles are dropped entirely and do not arm a commit.
  logic cfg_ok;
  assign cfg_ok = cfg_wr & (cfg_data < ANGLE_LIM);

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = cfg_ok & (cfg_ch == 2'(i));

    ign_scheduler_channel #(
      .ANGLE_W      (ANGLE_W),
      .MAX_DWELL_CYC(MAX_DWELL_CYC),
      .TMR_W        (TMR_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .synced   (synced),
      .tick     (tick),
      .angle    (angle),
      .en       (ch_en[i]),
      .wr       (ch_wr),
      .wr_sel   (cfg_sel),
      .wr_data  (cfg_data),
      .ovd_clr  (ovd_clr),
      .ign      (ign[i]),
      .overdwell(overdwell[i])
    );
  end

endmodule

// File: tb/tb_ign_scheduler.sv
// Directed bench for ign_scheduler: engine cycles at 4 clk per angle tick,
// expected coil states written out by hand at each step.
module tb_ign_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       synced;
  logic       tick;
  logic [9:0] angle;
  logic       cfg_wr;
  logic [1:0] cfg_ch;
  logic       cfg_sel;
  logic [9:0] cfg_data;
  logic [3:0] ch_en;
  logic       ovd_clr;
  logic [3:0] ign;
  logic [3:0] overdwell;

  int n_tests = 0;
  int n_fail  = 0;

  ign_scheduler dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .synced   (synced),
    .tick     (tick),
    .angle    (angle),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .ch_en    (ch_en),
    .ovd_clr  (ovd_clr),
    .ign      (ign),
    .overdwell(overdwell)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_at(input int a);
    angle = 10'(a);
    tick  = 1'b1;
    @(posedge clk);
    #1;
    tick  = 1'b0;
  endtask

  task automatic run_ticks(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      tick_at(a);
      clks(3);
    end
  endtask

  task automatic cfg(input int ch, input logic sel, input int data);
    cfg_ch   = 2'(ch);
    cfg_sel  = sel;
    cfg_data = 10'(data);
    cfg_wr   = 1'b1;
    @(posedge clk);
    #1;
    cfg_wr   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; synced = 1'b0; tick = 1'b0; angle = '0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
    ch_en = '0; ovd_clr = 1'b0;
    clks(3);
    check("rst_ign", ign, 4'b0000);
    check("rst_ovd", overdwell, 4'b0000);
    reset_n = 1'b1;
    clks(1);

    // Basic dwell/spark on channel 0
    cfg(0, 1'b0, 10);
    cfg(0, 1'b1, 40);
    synced = 1'b1;
    ch_en  = 4'b0001;
    run_ticks(0, 9);
    check("t1_pre", ign, 4'b0000);
    tick_at(10);
    check("t1_rise", ign, 4'b0001);
    clks(3);
    run_ticks(11, 39);
    check("t1_hold", ign, 4'b0001);
    tick_at(40);
    check("t1_fall", ign, 4'b0000);
    clks(3);
    run_ticks(41, 719);

    // Wrapping dwell on channel 1; out-of-range write to ch0 must be dropped
    cfg(1, 1'b0, 700);
    cfg(1, 1'b1, 20);
    cfg(0, 1'b1, 800);
    ch_en = 4'b0011;
    run_ticks(0, 699);
    check("t2_pre", ign, 4'b0000);
    tick_at(700);
    check("t2_rise", ign, 4'b0010);
    clks(3);
    run_ticks(701, 719);
    run_ticks(0, 9);
    check("t2_wrap", ign, 4'b0010);
    tick_at(10);
    check("t2_both", ign, 4'b0011);
    clks(3);
    run_ticks(11, 19);
    tick_at(20);
    check("t2_fall", ign, 4'b0001);
    check("t2_ovd", overdwell, 4'b0000);
    clks(3);
    ch_en = 4'b0001;
    run_ticks(21, 40);
    check("t2_ovr_ignored", ign, 4'b0000);
    run_ticks(41, 719);

    // Reprogram spark mid-dwell on channel 0
    run_ticks(0, 30);
    cfg(0, 1'b1, 35);
    check("t4_dwell", ign, 4'b0001);
    run_ticks(31, 34);
    tick_at(35);
    check("t4_no_early", ign, 4'b0001);
    clks(3);
    run_ticks(36, 39);
    tick_at(40);
    check("t4_old_spark", ign, 4'b0000);
    clks(3);

    // Channel 2 with ticks stalled mid-dwell
    cfg(2, 1'b0, 100);
    cfg(2, 1'b1, 200);
    ch_en = 4'b0101;
    run_ticks(41, 719);
    run_ticks(0, 34);
    check("t4_newcycle", ign, 4'b0001);
    tick_at(35);
    check("t4_new_spark", ign, 4'b0000);
    clks(3);
    run_ticks(36, 99);
    tick_at(100);
    check("t3_rise", ign, 4'b0100);
    clks(3);
    run_ticks(101, 150);
    clks(20000 - 203 - 1);
    check("t3_hold", ign, 4'b0100);
    check("t3_ovd_pre", overdwell, 4'b0000);
    clks(1);
    check("t3_timeout", ign, 4'b0000);
    check("t3_ovd", overdwell, 4'b0100);
    ovd_clr = 1'b1;
    clks(1);
    ovd_clr = 1'b0;
    check("t3_clr", overdwell, 4'b0000);

    // Loss of sync mid-dwell on channel 3
    cfg(3, 1'b0, 300);
    cfg(3, 1'b1, 400);
    ch_en = 4'b1001;
    run_ticks(151, 719);
    run_ticks(0, 349);
    check("t5_dwell", ign, 4'b1000);
    synced = 1'b0;
    clks(1);
    check("t5_drop", ign, 4'b0000);
    check("t5_ovd", overdwell, 4'b0000);
    synced = 1'b1;
    run_ticks(350, 719);
    run_ticks(0, 299);
    tick_at(300);
    check("t5_resume", ign, 4'b1000);
    clks(3);
    run_ticks(301, 309);
    check("t5_hold", ign, 4'b1000);

    // Asynchronous reset mid-dwell, then everything stays idle
    reset_n = 1'b0;
    #1;
    check("t6_async", ign, 4'b0000);
    clks(2);
    reset_n = 1'b1;
    ch_en = 4'b1111;
    run_ticks(0, 10);
    check("t6_idle_a", ign, 4'b0000);
    run_ticks(11, 719);
    check("t6_idle_b", ign, 4'b0000);
    check("t6_ovd", overdwell, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
